// File: rtl/fft_controller.sv
// fft_controller: sequencer for the shared single-port FFT sample memory.
// Flow is bit-reversed load, radix-2 DIT butterflies (read A, read B,
// write A, write B), then natural-order unload.
// Ports: clk/rst (sync, active-high); start/mode request a transform;
// busy/done report status; in_valid/in_ready is the load handshake;
// out_valid/out_ready is the result handshake. mem_addr, mem_wr_en and
// mem_bit_rev_en drive the memory. bf_cap_a/bf_cap_b/bf_sel_b/bf_tw_idx
// drive the butterfly datapath.
// Option FFT_CTRL_INVERSE_EN adds input inverse and output tw_conj.
module fft_controller #(
  parameter  int BIT_WIDTH = 8,
  parameter  int MODE_NUM  = 3,
  parameter  int FFT_SIZE  = 16,
  localparam int LOG2      = $clog2(FFT_SIZE),
  localparam int MW        = $clog2(MODE_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MW-1:0]   mode,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOG2-1:0] mem_addr,
  output logic            mem_wr_en,
  output logic            mem_bit_rev_en,
  output logic            bf_cap_a,
  output logic            bf_cap_b,
  output logic            bf_sel_b,
  output logic [LOG2-2:0] bf_tw_idx
`ifdef FFT_CTRL_INVERSE_EN
  ,
  input  logic            inverse,
  output logic            tw_conj
`endif
);

  if (BIT_WIDTH < 1) begin : g_bad_width
    $error("BIT_WIDTH must be positive");
  end
  if ((1 << LOG2) != FFT_SIZE || LOG2 < 2) begin : g_bad_size
    $error("FFT_SIZE must be a power of two >= 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [LOG2-1:0] s_q, s_d;
  logic [LOG2-2:0] k_q, k_d;
  logic [1:0]      ph_q, ph_d;

`ifdef FFT_CTRL_INVERSE_EN
  logic inv_q, inv_d;
`endif

  logic [7:0]      nlog;
  logic [LOG2-1:0] n_last;
  logic [LOG2-1:0] s_last;
  logic [LOG2-2:0] k_last;

  // Transform size from latched mode; sizes above FFT_SIZE clamp.
  always_comb begin
    nlog = 8'(mode_q) + 8'd2;
    if (nlog > 8'(LOG2)) nlog = 8'(LOG2);
    n_last = LOG2'((32'd1 << nlog) - 32'd1);
    k_last = (LOG2-1)'((32'd1 << (nlog - 8'd1)) - 32'd1);
    s_last = LOG2'(nlog - 8'd1);
  end

  logic [LOG2-1:0] k_ext;
  logic [LOG2-1:0] half;
  logic [LOG2-1:0] pos;
  logic [LOG2-1:0] addr_a;
  logic [LOG2-1:0] addr_b;
  logic [LOG2-1:0] tw_sh;

  // Butterfly k of stage s: insert a zero bit at position s of k.
  always_comb begin
    k_ext  = {1'b0, k_q};
    half   = LOG2'(1) << s_q;
    pos    = k_ext & (half - LOG2'(1));
    addr_a = ((k_ext >> s_q) << (s_q + LOG2'(1))) + pos;
    addr_b = addr_a + half;
    tw_sh  = LOG2'(LOG2 - 1) - s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
      ph_q    <= '0;
`ifdef FFT_CTRL_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
`ifdef FFT_CTRL_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;
    s_d            = s_q;
    k_d            = k_q;
    ph_d           = ph_q;
`ifdef FFT_CTRL_INVERSE_EN
    inv_d          = inv_q;
`endif
    busy           = (state_q != IDLE);
    done           = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    mem_addr       = '0;
    mem_wr_en      = 1'b0;
    mem_bit_rev_en = 1'b0;
    bf_cap_a       = 1'b0;
    bf_cap_b       = 1'b0;
    bf_sel_b       = 1'b0;
    bf_tw_idx      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = mode;
          cnt_d   = '0;
          s_d     = '0;
          k_d     = '0;
          ph_d    = '0;
`ifdef FFT_CTRL_INVERSE_EN
          inv_d   = inverse;
`endif
        end
      end

      LOAD: begin
        in_ready       = 1'b1;
        mem_bit_rev_en = 1'b1;
        mem_addr       = cnt_q;
        mem_wr_en      = in_valid;
        if (in_valid) begin
          if (cnt_q == n_last) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            s_d     = '0;
            k_d     = '0;
            ph_d    = '0;
          end else begin
            cnt_d = cnt_q + LOG2'(1);
          end
        end
      end

      COMPUTE: begin
        bf_tw_idx = (LOG2-1)'(pos << tw_sh);
        unique case (ph_q)
          2'd0: begin
            mem_addr = addr_a;
            bf_cap_a = 1'b1;
          end
          2'd1: begin
            mem_addr = addr_b;
            bf_cap_b = 1'b1;
          end
          2'd2: begin
            mem_addr  = addr_a;
            mem_wr_en = 1'b1;
          end
          2'd3: begin
            mem_addr  = addr_b;
            mem_wr_en = 1'b1;
            bf_sel_b  = 1'b1;
          end
        endcase
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          if (k_q == k_last) begin
            k_d = '0;
            if (s_q == s_last) begin
              state_d = UNLOAD;
              cnt_d   = '0;
            end else begin
              s_d = s_q + LOG2'(1);
            end
          end else begin
            k_d = k_q + (LOG2-1)'(1);
          end
        end
      end

      UNLOAD: begin
        out_valid = 1'b1;
        mem_addr  = cnt_q;
        if (out_ready) begin
          if (cnt_q == n_last) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LOG2'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_CTRL_INVERSE_EN
  assign tw_conj = (state_q == COMPUTE) & inv_q;
`endif

endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: directed and randomized checks of fft_controller
// against a loop-level model of the load/butterfly/unload schedule.
module tb_fft_controller;

  localparam int FFT_SIZE = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, in_ready, out_valid;
  logic [3:0] mem_addr;
  logic       mem_wr_en, mem_bit_rev_en;
  logic       bf_cap_a, bf_cap_b, bf_sel_b;
  logic [2:0] bf_tw_idx;
`ifdef FFT_CTRL_INVERSE_EN
  logic       inverse = 1'b0;
  logic       tw_conj;
`endif
  logic       inv_l;

  fft_controller #(
    .BIT_WIDTH (8),
    .MODE_NUM  (3),
    .FFT_SIZE  (FFT_SIZE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mem_addr       (mem_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_bit_rev_en (mem_bit_rev_en),
    .bf_cap_a       (bf_cap_a),
    .bf_cap_b       (bf_cap_b),
    .bf_sel_b       (bf_sel_b),
    .bf_tw_idx      (bf_tw_idx)
`ifdef FFT_CTRL_INVERSE_EN
    ,
    .inverse        (inverse),
    .tw_conj        (tw_conj)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc;

  typedef struct {
    int addr;
    bit ca;
    bit cb;
    bit wr;
    bit sb;
    int tw;
  } op_t;

  logic [15:0] obs;
  assign obs = {busy, done, in_ready, out_valid, mem_wr_en,
                mem_bit_rev_en, bf_cap_a, bf_cap_b, bf_sel_b,
                mem_addr, bf_tw_idx};

  function automatic logic [15:0] ev(bit bz, bit dn, bit ir, bit ov,
                                     bit wr, bit br, bit ca, bit cb,
                                     bit sb, int addr, int tw);
    return {bz, dn, ir, ov, wr, br, ca, cb, sb, 4'(addr), 3'(tw)};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_conj(string tag, bit exp_c);
`ifdef FFT_CTRL_INVERSE_EN
    chk(tag, 32'(tw_conj), 32'(exp_c));
`else
    if (exp_c) inv_l = inv_l;
`endif
  endtask

  // vmode: 0 in_valid high, 1 toggling, 2 random.
  task automatic run_fft(int md, int vmode, int stall_j, int stall_n,
                         bit rnd_out, bit abort);
    int n, ns, i, j, g, lst, ust, held;
    op_t q[$];
    n  = 4 << ((md > 2) ? 2 : md);
    ns = $clog2(n);
    // Standard DIT loop nest: stage, group, position within group.
    for (int s = 0; s < ns; s++) begin
      int h;
      h = 1 << s;
      for (int grp = 0; grp < n; grp += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          int tw;
          tw = p * (FFT_SIZE / (2 * h));
          q.push_back('{grp + p,     1, 0, 0, 0, tw});
          q.push_back('{grp + p + h, 0, 1, 0, 0, tw});
          q.push_back('{grp + p,     0, 0, 1, 0, tw});
          q.push_back('{grp + p + h, 0, 0, 1, 1, tw});
        end
      end
    end

    @(negedge clk);
    start = 1'b1;
    mode = 2'(md);
    in_valid = 1'b0;
    out_ready = 1'b0;
    inv_l = 1'($urandom);
`ifdef FFT_CTRL_INVERSE_EN
    inverse = inv_l;
`endif
    #1;
    cyc = 1;
    chk("idle_start", 32'(obs), 32'(0));

    i = 0; g = 0; lst = 0;
    while (i < n && g < 500) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom);
      mode = 2'($urandom);
`ifdef FFT_CTRL_INVERSE_EN
      inverse = 1'($urandom);
`endif
      if (vmode == 0) in_valid = 1'b1;
      else if (vmode == 1) in_valid = 1'(g % 2);
      else in_valid = ($urandom % 3) != 0;
      #1;
      chk($sformatf("load_%0d", i), 32'(obs),
          32'(ev(1, 0, 1, 0, in_valid, 1, 0, 0, 0, i, 0)));
      chk_conj("conj_load", 1'b0);
      if (in_valid) i++;
      else lst++;
      g++;
    end
    chk("load_count", i, n);

    foreach (q[idx]) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom);
      in_valid = 1'($urandom);
      #1;
      chk($sformatf("comp_%0d", idx), 32'(obs),
          32'(ev(1, 0, 0, 0, q[idx].wr, 0, q[idx].ca, q[idx].cb,
                 q[idx].sb, q[idx].addr, q[idx].tw)));
      chk_conj("conj_comp", inv_l);
      if (abort && idx == 2 * n + 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_idle", 32'(obs), 32'(0));
        chk_conj("conj_abort", 1'b0);
        return;
      end
    end
    in_valid = 1'b0;

    j = 0; g = 0; ust = 0; held = 0;
    while (j < n && g < 500) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom);
      if (j == stall_j && held < stall_n) out_ready = 1'b0;
      else if (rnd_out) out_ready = 1'($urandom);
      else out_ready = 1'b1;
      #1;
      chk($sformatf("unload_%0d", j), 32'(obs),
          32'(ev(1, 0, 0, 1, 0, 0, 0, 0, 0, j, 0)));
      chk_conj("conj_unload", 1'b0);
      if (out_ready) j++;
      else begin
        ust++;
        if (j == stall_j) held++;
      end
      g++;
    end
    chk("unload_count", j, n);

    @(negedge clk);
    cyc++;
    start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("done", 32'(obs), 32'(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("latency", cyc, 2 + 2 * n + 2 * n * ns + lst + ust);
    @(negedge clk);
    #1;
    chk("idle_after", 32'(obs), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    mode = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("reset_hold", 32'(obs), 32'(0));
      chk_conj("conj_reset", 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_release", 32'(obs), 32'(0));

    run_fft(0, 0, -1, 0, 1'b0, 1'b0);
    run_fft(2, 1, 7, 3, 1'b0, 1'b0);
    run_fft(2, 0, -1, 0, 1'b1, 1'b1);
    run_fft(1, 2, -1, 0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      int md;
      md = $urandom_range(0, 3);
      run_fft(md, 2, $urandom_range(0, 3), $urandom_range(0, 3),
              1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
